// File: rtl/exdiv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : exdiv_pkg
// Description : Shared types and constants for the divide-op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package exdiv_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Most negative dividend; with a divisor of -1 the quotient overflows
  localparam logic [7:0] DIV_MIN  = 8'h80;
  localparam logic [7:0] DIV_NEG1 = 8'hFF;
  // Quotient returned for a divide by zero (all ones)
  localparam logic [7:0] DBZ_QUOT = 8'hFF;

  // 8-bit two's complement negation
  function automatic logic [7:0] neg8(input logic [7:0] v);
    return 8'd0 - v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_op_sequencer
// Description : Front-end for an 8-bit signed restoring divider. Accepts one
//               request at a time, answers divide-by-zero and -128/-1
//               directly, otherwise runs the divider, sign-corrects the
//               remainder and returns a tagged response. A watchdog turns a
//               missing div_done into a timeout response.
// Revision    : 1.0 - initial release
// ============================================================================
module div_op_sequencer
  import exdiv_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  // request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [TAG_W-1:0] req_tag,
  // divider port
  output logic             div_start,
  output logic [7:0]       div_a,
  output logic [7:0]       div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [7:0]       div_quotient,
  input  logic [7:0]       div_remainder,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_quotient,
  output logic [7:0]       rsp_remainder,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dbz,
  output logic             rsp_ovf,
  output logic             rsp_tmo
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [7:0]         q_q, q_d;
  logic [7:0]         r_q, r_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic               w_accept;
  logic               w_operands_live;

  assign w_accept        = req_valid && req_ready;
  // Divider samples the operands in its first cycle, so keep them driven
  // from the start pulse until the result comes back.
  assign w_operands_live = (state_q == ISSUE) || (state_q == WAIT);

  assign req_ready     = (state_q == IDLE);
  assign div_start     = (state_q == ISSUE);
  assign div_a         = w_operands_live ? a_q : 8'd0;
  assign div_b         = w_operands_live ? b_q : 8'd0;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_quotient  = q_q;
  assign rsp_remainder = r_q;
  assign rsp_tag       = tag_q;
  assign rsp_dbz       = dbz_q;
  assign rsp_ovf       = ovf_q;
  assign rsp_tmo       = tmo_q;

  // Next-state, operand capture, result capture and watchdog
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    wdog_d  = wdog_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          a_d   = req_a;
          b_d   = req_b;
          tag_d = req_tag;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          tmo_d = 1'b0;
          if (req_b == 8'd0) begin
            q_d     = DBZ_QUOT;
            r_d     = req_a;
            dbz_d   = 1'b1;
            state_d = RESP;
          end else if ((req_a == DIV_MIN) && (req_b == DIV_NEG1)) begin
            q_d     = DIV_MIN;
            r_d     = 8'd0;
            ovf_d   = 1'b1;
            state_d = RESP;
          end else if (div_busy) begin
            // Divider has no reset and may still be finishing old work
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      DRAIN: begin
        if (!div_busy) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (div_done) begin
          q_d     = div_quotient;
          // Divider returns a magnitude; remainder follows the dividend sign
          r_d     = a_q[7] ? neg8(div_remainder) : div_remainder;
          state_d = RESP;
        end else if (wdog_q == WDOG_LAST) begin
          q_d     = 8'd0;
          r_d     = 8'd0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      tag_q   <= '0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule
`default_nettype wire
